// File: rtl/lock_pkg.sv
// Shared types and width helpers for the keypad lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    UNLK_READ1 = 3'd0,
    UNLK_READ2 = 3'd1,
    UNLK_CHECK = 3'd2,
    LK_READ    = 3'd3,
    LK_CHECK   = 3'd4,
    LK_LOCKOUT = 3'd5
  } lock_state_e;

  // Bits needed to hold every value 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic bit is_read_state(input lock_state_e s);
    return (s == UNLK_READ1) || (s == UNLK_READ2) || (s == LK_READ);
  endfunction

endpackage

// File: rtl/lock_entry_collector.sv
// Keypad digit shift register with digit counter; first digit ends up most significant.
module lock_entry_collector #(
  parameter int PASSCODE_LENGTH = 4,
  parameter int DIGIT_WIDTH     = 4,
  parameter int PASSCODE_WIDTH  = PASSCODE_LENGTH * DIGIT_WIDTH,
  parameter int COUNTER_WIDTH   = $clog2(PASSCODE_LENGTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      cancel_i,
  input  logic                      key_valid_i,
  input  logic [DIGIT_WIDTH-1:0]    key_i,
  output logic [PASSCODE_WIDTH-1:0] entry_o,
  output logic [PASSCODE_WIDTH-1:0] entry_next_o,
  output logic [COUNTER_WIDTH-1:0]  count_o,
  output logic                      last_digit_o
);

  localparam logic [COUNTER_WIDTH-1:0] FULL_CNT = COUNTER_WIDTH'(PASSCODE_LENGTH);
  localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(PASSCODE_LENGTH - 1);

  logic [PASSCODE_WIDTH-1:0] entry_q, entry_d, entry_next;
  logic [COUNTER_WIDTH-1:0]  count_q, count_d;
  logic                      full, accept;

  if (PASSCODE_LENGTH > 1) begin : g_shift
    assign entry_next = {entry_q[PASSCODE_WIDTH-DIGIT_WIDTH-1:0], key_i};
  end else begin : g_single
    assign entry_next = key_i;
  end

  // key_valid is a one-cycle strobe with no back-pressure: a digit is taken
  // on the edge it is high if collection is enabled, not cancelled and not full.
  assign full   = (count_q == FULL_CNT);
  assign accept = enable_i && key_valid_i && !cancel_i && !full;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (clear_i || (enable_i && cancel_i)) begin
      entry_d = '0;
      count_d = '0;
    end else if (accept) begin
      entry_d = entry_next;
      count_d = count_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign entry_o      = entry_q;
  assign entry_next_o = entry_next;
  assign count_o      = count_q;
  assign last_digit_o = accept && (count_q == LAST_CNT);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Digital lock controller: passcode programming (entered twice), unlock check,
// failed-attempt counting and timed lockout.
module keypad_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                        PASSCODE_LENGTH  = 4,
  parameter int                        DIGIT_WIDTH      = 4,
  parameter int                        PASSCODE_WIDTH   = PASSCODE_LENGTH * DIGIT_WIDTH,
  parameter int                        COUNTER_WIDTH    = count_width(PASSCODE_LENGTH),
  parameter int                        MAX_ATTEMPTS     = 3,
  parameter int                        LOCKOUT_CYCLES   = 1000,
  parameter logic [PASSCODE_WIDTH-1:0] DEFAULT_PASSCODE = 16'h8148
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DIGIT_WIDTH-1:0]                key,
  input  logic                                  key_valid,
  input  logic                                  cancel,
  output logic                                  locked,
  output logic                                  lockout,
  output logic                                  error,
  output logic [COUNTER_WIDTH-1:0]              entry_count,
  output logic [count_width(MAX_ATTEMPTS)-1:0]  fail_count,
  output logic [2:0]                            dbg_state
);

  localparam int FAIL_WIDTH = count_width(MAX_ATTEMPTS);
  localparam int LOCK_WIDTH = count_width(LOCKOUT_CYCLES);
  localparam logic [FAIL_WIDTH-1:0] FAIL_LIMIT = FAIL_WIDTH'(MAX_ATTEMPTS);
  localparam logic [LOCK_WIDTH-1:0] LOCK_LOAD  = LOCK_WIDTH'(LOCKOUT_CYCLES);
  localparam logic [LOCK_WIDTH-1:0] LOCK_ONE   = LOCK_WIDTH'(1);

  lock_state_e               state_q, state_d;
  logic [PASSCODE_WIDTH-1:0] passcode_q, passcode_d;
  logic [PASSCODE_WIDTH-1:0] confirm_q, confirm_d;
  logic                      locked_q, locked_d;
  logic                      error_q, error_d;
  logic [FAIL_WIDTH-1:0]     fail_q, fail_d;
  logic [LOCK_WIDTH-1:0]     lock_cnt_q, lock_cnt_d;

  logic                      collect_en, collect_clear, last_digit;
  logic [PASSCODE_WIDTH-1:0] entry, entry_next;

  assign collect_en = is_read_state(state_q);

  lock_entry_collector #(
    .PASSCODE_LENGTH (PASSCODE_LENGTH),
    .DIGIT_WIDTH     (DIGIT_WIDTH),
    .PASSCODE_WIDTH  (PASSCODE_WIDTH),
    .COUNTER_WIDTH   (COUNTER_WIDTH)
  ) u_collector (
    .clock        (clock),
    .reset        (reset),
    .enable_i     (collect_en),
    .clear_i      (collect_clear),
    .cancel_i     (cancel),
    .key_valid_i  (key_valid),
    .key_i        (key),
    .entry_o      (entry),
    .entry_next_o (entry_next),
    .count_o      (entry_count),
    .last_digit_o (last_digit)
  );

  always_comb begin
    state_d       = state_q;
    passcode_d    = passcode_q;
    confirm_d     = confirm_q;
    locked_d      = locked_q;
    error_d       = 1'b0;
    fail_d        = fail_q;
    lock_cnt_d    = lock_cnt_q;
    collect_clear = 1'b0;
    case (state_q)
      UNLK_READ1: begin
        // The final digit goes straight into the confirm register so the
        // collector can restart at zero for the confirmation entry.
        if (last_digit) begin
          confirm_d     = entry_next;
          collect_clear = 1'b1;
          state_d       = UNLK_READ2;
        end
      end
      UNLK_READ2: if (last_digit) state_d = UNLK_CHECK;
      UNLK_CHECK: begin
        collect_clear = 1'b1;
        confirm_d     = '0;
        if (entry == confirm_q) begin
          passcode_d = entry;
          locked_d   = 1'b1;
          state_d    = LK_READ;
        end else begin
          error_d = 1'b1;
          state_d = UNLK_READ1;
        end
      end
      LK_READ: if (last_digit) state_d = LK_CHECK;
      LK_CHECK: begin
        collect_clear = 1'b1;
        if (entry == passcode_q) begin
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = UNLK_READ1;
        end else begin
          error_d = 1'b1;
          fail_d  = fail_q + FAIL_WIDTH'(1);
          if (fail_d == FAIL_LIMIT) begin
            lock_cnt_d = LOCK_LOAD;
            state_d    = LK_LOCKOUT;
          end else begin
            state_d = LK_READ;
          end
        end
      end
      LK_LOCKOUT: begin
        if (lock_cnt_q == LOCK_ONE) begin
          fail_d  = '0;
          state_d = LK_READ;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_ONE;
        end
      end
      default: begin
        // Unused encodings fall back to the read state of whichever side
        // the actuator is currently on.
        collect_clear = 1'b1;
        state_d       = locked_q ? LK_READ : UNLK_READ1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= UNLK_READ1;
      passcode_q <= DEFAULT_PASSCODE;
      confirm_q  <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      passcode_q <= passcode_d;
      confirm_q  <= confirm_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign lockout    = (state_q == LK_LOCKOUT);
  assign error      = error_q;
  assign fail_count = fail_q;
  assign dbg_state  = state_q;

endmodule
